fib_index_ctrl: RTL
===================

// Module: fib_index_ctrl
// PURPOSE
//  Request/response controller that sequences a Fibonacci datapath to return F(idx) for a requested index.
//  Holds the F(n-1)/F(n) register pair internally and steps it once per cycle until the index is reached.
//  Flags results that overflowed FIB_BITS.
//  Sits between a host (valid/ready request) and downstream consumers (valid/ready response).
// PARAMETERS
//  FIB_BITS  10  width of Fibonacci values; F(16)=987 is the largest exact value at default
//  IDX_BITS  5   width of requested index; idx range 0..2^IDX_BITS-1
// PORTS
//  clk       in   1         clock, rising edge
//  nrst      in   1         reset, asynchronous, active-low
//  req_valid in   1         host presents a request
//  req_ready out  1         controller can accept a request (IDLE only)
//  req_idx   in   IDX_BITS  requested index n; captured on accept
//  rsp_valid out  1         response available (DONE only)
//  rsp_ready in   1         consumer takes the response
//  rsp_f     out  FIB_BITS  F(n), per overflow rules below
//  rsp_ovf   out  1         F(n) exceeded 2^FIB_BITS-1
//  busy      out  1         state != IDLE
// BEHAVIOUR
//  Reset (async, nrst=0): state=IDLE, a=0, b=0, cnt=0, rsp_f=0, rsp_ovf=0.
//   Resulting outputs: req_ready=1, rsp_valid=0, busy=0. Reset mid-RUN/DONE aborts with no response.
//  FSM states: IDLE, RUN, DONE.
//  IDLE: req_ready=1. On req_valid&req_ready:
//   a<=0 (F0), b<=1 (F1), cnt<=req_idx, ovf_a<=0, ovf_b<=0, go to RUN.
//  RUN:
//   - cnt!=0: a<=b, b<=a+b, cnt<=cnt-1.
//     ovf_a<=ovf_b; ovf_b<=ovf_a|ovf_b|carry(a+b), with the sum computed at FIB_BITS+1 bits.
//   - cnt==0: rsp_f<=a, rsp_ovf<=ovf_a, go to DONE.
//  DONE: rsp_valid=1; rsp_f/rsp_ovf held stable until rsp_valid&rsp_ready, then go to IDLE.
//  Latency: rsp_valid rises exactly req_idx+1 clk edges after the accept edge (idx=0 -> 1 cycle).
//  Throughput: req_ready=0 in RUN and DONE.
//   A request presented during DONE is not accepted; it is accepted in IDLE on the following cycle.
//   This gives a 1-cycle bubble minimum.
//  req_idx changes after accept have no effect. rsp_ready outside DONE is ignored.
//  req_valid may drop before accept without penalty.
//  busy=1 from the edge after accept through the response handshake edge.
// CONFIGURATION
//  FIB_SAT_EN undefined (default):
//   - b<=(a+b) mod 2^FIB_BITS (wrap); rsp_f = F(n) mod 2^FIB_BITS.
//  FIB_SAT_EN defined:
//   - b<=2^FIB_BITS-1 whenever carry, ovf_a or ovf_b is set; otherwise a+b.
//   - rsp_f = all-ones for any overflowed result.
//  Both variants: rsp_ovf is identical and timing is identical.
// TESTING
//  1 Reset: nrst=0 mid-RUN (idx=10, 4 cycles in) -> same cycle req_ready=1, rsp_valid=0, busy=0, rsp_f=0.
//    Then idx=10 -> rsp_f=55.
//  2 Small idx: idx=0 -> rsp_f=0 after 1 edge; idx=1 -> 1 after 2; idx=2 -> 1 after 3; rsp_ovf=0 for all.
//  3 Largest exact value: idx=16 -> rsp_f=987, rsp_ovf=0, rsp_valid exactly 17 edges after accept.
//  4 Overflow: idx=17 -> rsp_ovf=1, rsp_f=573 (wrap) or 1023 (FIB_SAT_EN).
//    idx=20 -> rsp_f=621 (wrap) or 1023 (FIB_SAT_EN), rsp_ovf=1.
//  5 Backpressure: idx=5, rsp_ready=0 for 5 cycles -> rsp_valid=1, rsp_f=5 held stable, req_ready=0.
//    req_valid with idx=7 during DONE is not accepted.
//  6 Back-to-back: response handshake then req idx=7 held -> accepted 1 cycle after the handshake.
//    rsp_f=13 arrives 8 edges after that accept.

Source files
------------

// File: rtl/fib_index_ctrl.sv
// Request/response Fibonacci controller: accepts an index, steps an F(n-1)/F(n) pair once per cycle, returns F(idx) with overflow flag.
// Optional build macro FIB_SAT_EN: saturate overflowed values to all-ones instead of wrapping.
module fib_index_ctrl #(
  parameter int FIB_BITS = 10,
  parameter int IDX_BITS = 5
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [IDX_BITS-1:0] req_idx,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [FIB_BITS-1:0] rsp_f,
  output logic                rsp_ovf,
  output logic                busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]          state;
  logic [FIB_BITS-1:0] aQ;
  logic [FIB_BITS-1:0] bQ;
  logic [IDX_BITS-1:0] cntQ;
  logic                ovfA;
  logic                ovfB;
  logic [FIB_BITS:0]   sum;
  logic                carry;
  logic [FIB_BITS-1:0] nextB;

  assign sum   = {1'b0, aQ} + {1'b0, bQ};
  assign carry = sum[FIB_BITS];

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    nextB = sum[FIB_BITS-1:0];
`ifdef FIB_SAT_EN
    if (carry || ovfA || ovfB) nextB = '1;
`endif
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= IDLE;
      aQ      <= '0;
      bQ      <= '0;
      cntQ    <= '0;
      ovfA    <= 1'b0;
      ovfB    <= 1'b0;
      rsp_f   <= '0;
      rsp_ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            aQ    <= '0;
            bQ    <= {{(FIB_BITS-1){1'b0}}, 1'b1};
            cntQ  <= req_idx;
            ovfA  <= 1'b0;
            ovfB  <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          if (cntQ != '0) begin
            aQ   <= bQ;
            bQ   <= nextB;
            cntQ <= cntQ - 1'b1;
            ovfA <= ovfB;
            ovfB <= ovfA | ovfB | carry;
          end else begin
            rsp_f   <= aQ;
            rsp_ovf <= ovfA;
            state   <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
